// File: rtl/mul8_pkg.sv
// Shared definitions for the 8-lane byte multiplier: SEW encoding and issue-FSM states.
package mul8_pkg;

  localparam logic [1:0] SEW_8   = 2'd0;
  localparam logic [1:0] SEW_16  = 2'd1;
  localparam logic [1:0] SEW_32  = 2'd2;
  localparam logic [1:0] SEW_ILL = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StPh1,
    StPh2,
    StDone
  } issue_state_e;

endpackage

// File: rtl/mul8x8_u.sv
// Unsigned 8x8 -> 16-bit combinational multiplier, one per byte lane.
module mul8x8_u (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = {8'd0, a} * {8'd0, b};

endmodule

// File: rtl/mul_pp_issue_8.sv
// Issue front end: latches operands, starts the combiner and presents eight byte
// products per phase in the lane order the combiner expects.
module mul_pp_issue_8
  import mul8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  sew,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        pp_start,
  output logic [1:0]  pp_sew,
  output logic [15:0] pp_out_1,
  output logic [15:0] pp_out_2,
  output logic [15:0] pp_out_3,
  output logic [15:0] pp_out_4,
  output logic [15:0] pp_out_5,
  output logic [15:0] pp_out_6,
  output logic [15:0] pp_out_7,
  output logic [15:0] pp_out_8,
  output logic        res_valid,
  output logic        err
);

  issue_state_e state_q;
  logic [31:0]  a_q, b_q;
  logic [1:0]   sew_q;
  logic [15:0]  pp_q [8];
  logic [7:0]   a_byte [4];
  logic [7:0]   b_byte [4];
  logic [7:0]   mul_a [8];
  logic [7:0]   mul_b [8];
  logic [15:0]  prod [8];
  logic         phase2;

  // Phase-2 operands are selected while sitting in PH1 so they load on its exit edge.
  assign phase2   = (state_q == StPh1);
  assign in_ready = (state_q == StIdle);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_byte[i] = a_q[8*i +: 8];
      b_byte[i] = b_q[8*i +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      mul_a[i] = 8'd0;
      mul_b[i] = 8'd0;
    end
    case (sew_q)
      SEW_8: begin
        for (int i = 0; i < 4; i++) begin
          mul_a[i] = a_byte[i];
          mul_b[i] = b_byte[i];
        end
      end
      SEW_16: begin
        // Two independent 16x16 lanes, each split into four byte products.
        for (int h = 0; h < 2; h++) begin
          for (int j = 0; j < 4; j++) begin
            mul_a[4*h + j] = a_byte[2*h + (j % 2)];
            mul_b[4*h + j] = b_byte[2*h + (j / 2)];
          end
        end
      end
      SEW_32: begin
        for (int i = 0; i < 4; i++) begin
          mul_a[i]     = a_byte[i];
          mul_b[i]     = phase2 ? b_byte[2] : b_byte[0];
          mul_a[i + 4] = a_byte[i];
          mul_b[i + 4] = phase2 ? b_byte[3] : b_byte[1];
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane
    mul8x8_u u_mul (
      .a (mul_a[g]),
      .b (mul_b[g]),
      .p (prod[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      sew_q     <= SEW_8;
      pp_start  <= 1'b0;
      pp_sew    <= SEW_8;
      res_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 8; i++) pp_q[i] <= '0;
    end else begin
      pp_start  <= 1'b0;
      pp_sew    <= SEW_8;
      res_valid <= 1'b0;
      err       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sew_q <= sew;
            if (sew == SEW_ILL) begin
              err <= 1'b1;
            end else begin
              state_q  <= StStart;
              pp_start <= 1'b1;
              pp_sew   <= sew;
            end
          end
        end
        StStart: begin
          state_q <= StPh1;
          for (int i = 0; i < 8; i++) pp_q[i] <= prod[i];
        end
        StPh1: begin
          if (sew_q == SEW_32) begin
            state_q <= StPh2;
            for (int i = 0; i < 8; i++) pp_q[i] <= prod[i];
          end else begin
            state_q   <= StDone;
            res_valid <= 1'b1;
            for (int i = 0; i < 8; i++) pp_q[i] <= '0;
          end
        end
        StPh2: begin
          state_q   <= StDone;
          res_valid <= 1'b1;
          for (int i = 0; i < 8; i++) pp_q[i] <= '0;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pp_out_1 = pp_q[0];
  assign pp_out_2 = pp_q[1];
  assign pp_out_3 = pp_q[2];
  assign pp_out_4 = pp_q[3];
  assign pp_out_5 = pp_q[4];
  assign pp_out_6 = pp_q[5];
  assign pp_out_7 = pp_q[6];
  assign pp_out_8 = pp_q[7];

endmodule

// File: tb/tb_mul_pp_issue_8.sv
// Bench for mul_pp_issue_8: directed and random requests against a byte-product model.
module tb_mul_pp_issue_8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sew;
  logic [31:0] op_a, op_b;
  logic        pp_start;
  logic [1:0]  pp_sew;
  logic [15:0] pp_out_1, pp_out_2, pp_out_3, pp_out_4;
  logic [15:0] pp_out_5, pp_out_6, pp_out_7, pp_out_8;
  logic        res_valid, err;

  logic [15:0] pp [8];
  logic [15:0] cap1 [8];
  logic [15:0] cap2 [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_pp_issue_8 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sew       (sew),
    .op_a      (op_a),
    .op_b      (op_b),
    .pp_start  (pp_start),
    .pp_sew    (pp_sew),
    .pp_out_1  (pp_out_1),
    .pp_out_2  (pp_out_2),
    .pp_out_3  (pp_out_3),
    .pp_out_4  (pp_out_4),
    .pp_out_5  (pp_out_5),
    .pp_out_6  (pp_out_6),
    .pp_out_7  (pp_out_7),
    .pp_out_8  (pp_out_8),
    .res_valid (res_valid),
    .err       (err)
  );

  always_comb begin
    pp[0] = pp_out_1; pp[1] = pp_out_2; pp[2] = pp_out_3; pp[3] = pp_out_4;
    pp[4] = pp_out_5; pp[5] = pp_out_6; pp[6] = pp_out_7; pp[7] = pp_out_8;
  end

  function automatic int unsigned byte_of(input logic [31:0] x, input int k);
    return (x >> (8 * k)) & 32'hFF;
  endfunction

  // Expected product on 0-based lane for the given phase (0 or 1).
  function automatic logic [15:0] exp_pp(input logic [31:0] a, input logic [31:0] b,
                                         input int s, input int phase, input int lane);
    int unsigned r;
    r = 0;
    if (s == 0) begin
      if (lane < 4) r = byte_of(a, lane) * byte_of(b, lane);
    end else if (s == 1) begin
      r = byte_of(a, 2 * (lane / 4) + (lane % 2)) * byte_of(b, 2 * (lane / 4) + ((lane % 4) / 2));
    end else begin
      r = byte_of(a, lane % 4) * byte_of(b, 2 * phase + lane / 4);
    end
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; sew = 2'd0; op_a = '0; op_b = '0;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || pp_start !== 1'b0 || pp_sew !== 2'd0 || res_valid !== 1'b0 ||
        err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b st=%b sew=%0d rv=%b err=%b, want 1 0 0 0 0",
               in_ready, pp_start, pp_sew, res_valid, err);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pp[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_pp%0d: got %h want 0000", i + 1, pp[i]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  // Full transaction from idle; captures phase products into cap1/cap2.
  task automatic test_product(input logic [31:0] a, input logic [31:0] b, input int s);
    longint unsigned sum, want;
    in_valid = 1'b1; op_a = a; op_b = b; sew = 2'(s);
    tick();
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; sew = 2'($urandom_range(0, 3));
    checks++;
    if (pp_start !== 1'b1 || pp_sew !== 2'(s) || in_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL start: got st=%b sew=%0d rdy=%b rv=%b, want 1 %0d 0 0",
               pp_start, pp_sew, in_ready, res_valid, s);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      cap1[i] = pp[i];
      checks++;
      if (pp[i] !== exp_pp(a, b, s, 0, i)) begin
        errors++;
        $display("FAIL ph1_pp%0d sew=%0d a=%h b=%h: got %h want %h",
                 i + 1, s, a, b, pp[i], exp_pp(a, b, s, 0, i));
      end
    end
    checks++;
    if (pp_start !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL ph1_ctrl: got st=%b rv=%b want 0 0", pp_start, res_valid);
    end
    for (int i = 0; i < 8; i++) cap2[i] = 16'h0;
    if (s == 2) begin
      tick();
      for (int i = 0; i < 8; i++) begin
        cap2[i] = pp[i];
        checks++;
        if (pp[i] !== exp_pp(a, b, s, 1, i)) begin
          errors++;
          $display("FAIL ph2_pp%0d a=%h b=%h: got %h want %h",
                   i + 1, a, b, pp[i], exp_pp(a, b, s, 1, i));
        end
      end
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL ph2_rv: got %b want 0", res_valid);
      end
      // Weighted recombination must reproduce the full 32x32 product.
      sum = 0;
      for (int i = 0; i < 8; i++) begin
        sum += longint'(cap1[i]) << (8 * (i % 4) + 8 * (i / 4));
        sum += longint'(cap2[i]) << (8 * (i % 4) + 8 * (i / 4) + 16);
      end
      want = longint'(a) * longint'(b);
      checks++;
      if (sum !== want) begin
        errors++;
        $display("FAIL combine32: got %h want %h", sum, want);
      end
    end else if (s == 1) begin
      for (int h = 0; h < 2; h++) begin
        sum = 0;
        for (int j = 0; j < 4; j++) sum += longint'(cap1[4*h + j]) << (8 * (j % 2 + j / 2));
        want = longint'((a >> (16 * h)) & 32'hFFFF) * longint'((b >> (16 * h)) & 32'hFFFF);
        checks++;
        if (sum !== want) begin
          errors++;
          $display("FAIL combine16 lane%0d: got %h want %h", h, sum, want);
        end
      end
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done: got rv=%b rdy=%b want 1 0", res_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pp[i] !== 16'h0) begin
        errors++;
        $display("FAIL done_pp%0d: got %h want 0000", i + 1, pp[i]);
      end
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after: got rv=%b rdy=%b want 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_sew8();
    logic [15:0] want [4];
    want[0] = 16'h0005; want[1] = 16'h000C; want[2] = 16'h0015; want[3] = 16'h0020;
    test_product(32'h04030201, 32'h08070605, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap1[i] !== want[i]) begin
        errors++;
        $display("FAIL sew8_lit%0d: got %h want %h", i + 1, cap1[i], want[i]);
      end
    end
  endtask

  task automatic test_sew16();
    logic [15:0] want [8];
    longint unsigned lane0;
    want[0] = 16'h1860; want[1] = 16'h0870; want[2] = 16'h1178; want[3] = 16'h060C;
    want[4] = 16'h01FE; want[5] = 16'h0000; want[6] = 16'h0000; want[7] = 16'h0000;
    test_product(32'h00FF1234, 32'h00025678, 1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap1[i] !== want[i]) begin
        errors++;
        $display("FAIL sew16_lit%0d: got %h want %h", i + 1, cap1[i], want[i]);
      end
    end
    lane0 = longint'(cap1[0]) + (longint'(cap1[1]) << 8) + (longint'(cap1[2]) << 8) +
            (longint'(cap1[3]) << 16);
    checks++;
    if (lane0 !== 64'h06260060) begin
      errors++;
      $display("FAIL sew16_lane0: got %h want 06260060", lane0);
    end
  endtask

  task automatic test_sew32();
    test_product(32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap1[i] !== 16'hFE01 || cap2[i] !== 16'hFE01) begin
        errors++;
        $display("FAIL sew32_lit%0d: got %h/%h want fe01/fe01", i + 1, cap1[i], cap2[i]);
      end
    end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; sew = 2'd3; op_a = 32'h11111111; op_b = 32'h22222222;
    tick();
    checks++;
    if (err !== 1'b1 || pp_start !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal: got err=%b st=%b rdy=%b want 1 0 1", err, pp_start, in_ready);
    end
    sew = 2'd0; op_a = 32'h00000003; op_b = 32'h00000007;
    tick();
    in_valid = 1'b0;
    checks++;
    if (pp_start !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_next: got st=%b err=%b want 1 0", pp_start, err);
    end
    tick();
    checks++;
    if (pp[0] !== 16'h0015) begin
      errors++;
      $display("FAIL illegal_next_pp1: got %h want 0015", pp[0]);
    end
    for (int n = 0; n < 10 && !in_ready; n++) tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_idle: got rdy=%b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; sew = 2'd0; op_a = 32'h0A0B0C0D; op_b = 32'h02020202;
    tick();                         // cycle 1
    op_a = 32'h01010101; op_b = 32'h05050505;
    tick();                         // cycle 2
    checks++;
    if (pp[0] !== 16'h001A || pp[3] !== 16'h0014) begin
      errors++;
      $display("FAIL b2b_first: got %h %h want 001a 0014", pp[0], pp[3]);
    end
    tick();                         // cycle 3
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rv: got %b want 1", res_valid);
    end
    tick();                         // cycle 4
    checks++;
    if (pp_start !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got st=%b rdy=%b want 0 1", pp_start, in_ready);
    end
    tick();                         // cycle 5
    in_valid = 1'b0;
    checks++;
    if (pp_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_start: got %b want 1", pp_start);
    end
    tick();                         // cycle 6
    checks++;
    if (pp[0] !== 16'h0005 || pp[2] !== 16'h0005) begin
      errors++;
      $display("FAIL b2b_second: got %h %h want 0005 0005", pp[0], pp[2]);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    bit seen_rv;
    in_valid = 1'b1; sew = 2'd2; op_a = 32'hDEADBEEF; op_b = 32'hCAFEF00D;
    tick();
    in_valid = 1'b0;
    tick();                         // in PH1
    reset = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || pp_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got rdy=%b rv=%b st=%b want 1 0 0",
               in_ready, res_valid, pp_start);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pp[i] !== 16'h0) begin
        errors++;
        $display("FAIL rst_mid_pp%0d: got %h want 0000", i + 1, pp[i]);
      end
    end
    reset = 1'b0;
    seen_rv = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (res_valid) seen_rv = 1'b1;
    end
    checks++;
    if (seen_rv !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rv: got res_valid after reset, want none");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      test_product($urandom, $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_sew8();
    test_sew16();
    test_sew32();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_pp_issue_8.md
Name: mul_pp_issue_8

Overview:
- Front end of the 8-lane byte multiplier: accepts two 32-bit operands and an element width (SEW).
- Drives the carry-save combiner's start/sew request.
- Presents eight 16-bit unsigned 8x8 byte products on the combiner's mult_out_1..8 inputs, in the exact cycle and lane weighting the combiner consumes: one phase for 8/16-bit, two phases for 32-bit.
- Sits between the vector execution-unit issue logic and the combiner, and signals when the combiner's product outputs are valid.

Parameters:
- None. Widths are fixed by the combiner interface: 32-bit operands, 16-bit byte products.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept a request; high only in IDLE
- sew  in  2  0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = illegal
- op_a  in  32  multiplicand
- op_b  in  32  multiplier
- pp_start  out  1  to combiner start
- pp_sew  out  2  to combiner sew
- pp_out_1..pp_out_8  out  16 each  to combiner mult_out_1..8, unsigned byte products
- res_valid  out  1  one-cycle pulse: combiner product_1..4 valid this cycle
- err  out  1  one-cycle pulse: illegal sew request was accepted and dropped

Behaviour:
- Reset values: state IDLE, pp_start=0, pp_sew=0, all pp_out=0, res_valid=0, err=0, latched operands=0. in_ready=1 after reset.
- Handshake: a request is accepted on a clock edge where in_valid & in_ready. On that edge op_a, op_b and sew are latched. in_ready is low in every state except IDLE, and there is no back-pressure from the combiner.
- FSM states: IDLE, START, PH1, PH2, DONE.
- IDLE:
  - On accept with sew<3: go to START.
  - On accept with sew==3: stay in IDLE and pulse err the next cycle. No pp_start is issued.
- START:
  - pp_start=1 and pp_sew=latched sew, both held for exactly this cycle.
  - Next state is PH1. pp_out registers load the phase-1 products on this edge.
- PH1:
  - pp_out holds the phase-1 products.
  - If sew==2: next state PH2 and the phase-2 products load on this edge.
  - Otherwise: next state DONE.
- PH2: pp_out holds the phase-2 products; next state DONE.
- DONE: res_valid=1, pp_out=0; next state IDLE.
- Outside PH1/PH2, all pp_out are 0 and pp_start=0.
- Byte notation: aK = op_a[8K+7:8K], bK likewise. Products are unsigned 8x8 to 16-bit, with no sign handling.
- sew=0, phase 1: pp_out_k = a(k-1)*b(k-1) for k=1..4; pp_out_5..8 = 0.
- sew=1, phase 1 (two 16x16 lanes):
  - pp_out_1=a0*b0, pp_out_2=a1*b0, pp_out_3=a0*b1, pp_out_4=a1*b1
  - pp_out_5=a2*b2, pp_out_6=a3*b2, pp_out_7=a2*b3, pp_out_8=a3*b3
- sew=2, phase 1:
  - pp_out_1..4 = a0*b0, a1*b0, a2*b0, a3*b0
  - pp_out_5..8 = a0*b1, a1*b1, a2*b1, a3*b1
  - Byte weights: 0,8,16,24 and 8,16,24,32.
- sew=2, phase 2: same mapping with b2 replacing b0 and b3 replacing b1. The combiner applies the +16 weight offset.
- Latency, with accept at edge 0:
  - pp_start in cycle 1, phase 1 in cycle 2.
  - res_valid in cycle 3 for sew 0/1; phase 2 in cycle 3 and res_valid in cycle 4 for sew 2.
  - Throughput: one request per 4 cycles (sew 0/1) or per 5 cycles (sew 2).
- Operand changes after accept have no effect; the latched copies are used.
- in_valid held high in DONE is not accepted until IDLE, i.e. the cycle after res_valid.
- Reset mid-operation (any state): immediate return to IDLE with all outputs at their reset values. The combiner shares the reset, so no partial result is reported.

Decomposition:
- Shared package mul8_pkg: SEW encoding localparams (SEW_8=0, SEW_16=1, SEW_32=2) and the issue-FSM state enum. The combiner is to import the same SEW constants.
- One sub-module, mul8x8_u: an unsigned 8x8 to 16-bit combinational multiplier. Instantiate it eight times, with operand byte muxes selected by sew and phase.

Test Plan:
- Reset mid-PH1 of a sew=2 request -> next cycle state IDLE, pp_out all 0, in_ready=1, no res_valid.
- sew=0, op_a=0x04030201, op_b=0x08070605:
  - Cycle 2: pp_out_1..4 = 0x0005, 0x000C, 0x0015, 0x0020; pp_out_5..8 = 0.
  - res_valid in cycle 3.
- sew=1, op_a=0x00FF_1234, op_b=0x0002_5678:
  - Cycle 2: pp_out_1=0x34*0x78=0x1860, pp_out_2=0x12*0x78=0x0870, pp_out_3=0x34*0x56=0x1178, pp_out_4=0x12*0x56=0x060C, pp_out_5=0xFF*0x02=0x01FE, pp_out_6..8=0.
  - Combined lane-0 product = 0x06260060.
- sew=2, op_a=0xFFFFFFFF, op_b=0xFFFFFFFF:
  - pp_start in cycle 1; all eight pp_out=0xFE01 in cycles 2 and 3; res_valid in cycle 4.
  - Combiner product_2:product_1 = 0xFFFFFFFE_00000001.
- sew=3 request -> err pulses in cycle 1, pp_start stays 0, in_ready stays 1, and the next valid request is accepted immediately.
- Back-to-back requests with in_valid held high and operands changed in cycle 1 -> first result uses the operands latched at edge 0; second accept occurs the cycle after res_valid.
